// File: rtl/food_vend_ctrl.sv
// Vending controller: coin credit accumulation, priced selection, dispense handshake and unit-by-unit change return.
// Optional per-item stock counting and sold_out output are enabled with `define FOOD_STOCK_COUNT_EN.
module food_vend_ctrl #(
  parameter int unsigned PRICE0     = 5,
  parameter int unsigned PRICE1     = 7,
  parameter int unsigned PRICE2     = 10,
  parameter int unsigned PRICE3     = 12,
  parameter int unsigned STOCK_INIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [3:0] coin_val,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  input  logic       disp_done,
  output logic [7:0] credit,
  output logic       disp_req,
  output logic [1:0] disp_item,
  output logic       change_pulse,
  output logic       busy,
  output logic       err_funds,
`ifdef FOOD_STOCK_COUNT_EN
  output logic       coin_reject,
  output logic       sold_out
`else
  output logic       coin_reject
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CREDIT   = 2'd1;
  localparam logic [1:0] DISPENSE = 2'd2;
  localparam logic [1:0] CHANGE   = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic       disp_req_q, disp_req_d;
  logic [1:0] disp_item_q, disp_item_d;
  logic       entry_q, entry_d;
  logic       err_funds_q, err_funds_d;
  logic       coin_reject_q, coin_reject_d;

  logic [8:0] coin_sum;
  logic       coin_ok;
  logic [8:0] credit_pre;
  logic [8:0] price;
  logic [1:0] rest_state;

`ifdef FOOD_STOCK_COUNT_EN
  logic [3:0] stock_q [4];
  logic [3:0] stock_d [4];
  logic       sold_out_q, sold_out_d;
`endif

  function automatic logic [8:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 9'(PRICE0);
      2'd1:    price_of = 9'(PRICE1);
      2'd2:    price_of = 9'(PRICE2);
      default: price_of = 9'(PRICE3);
    endcase
  endfunction

  assign coin_sum   = {1'b0, credit_q} + 9'(coin_val);
  assign coin_ok    = coin_valid && (coin_val != '0) && !coin_sum[8];
  assign credit_pre = coin_ok ? coin_sum : {1'b0, credit_q};
  assign price      = price_of(sel_item);
  assign rest_state = (credit_pre != '0) ? CREDIT : IDLE;

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_req_d    = disp_req_q;
    disp_item_d   = disp_item_q;
    entry_d       = 1'b0;
    err_funds_d   = 1'b0;
    coin_reject_d = 1'b0;
`ifdef FOOD_STOCK_COUNT_EN
    sold_out_d    = 1'b0;
    stock_d       = stock_q;
`endif
    case (state_q)
      IDLE, CREDIT: begin
        coin_reject_d = coin_valid && !coin_ok;
        credit_d      = credit_pre[7:0];
        state_d       = rest_state;
        // Price check uses the pre-coin credit; an accepted coin still lands in the result.
        if (cancel) begin
          if (state_q == CREDIT) state_d = CHANGE;
        end else if (sel_valid) begin
`ifdef FOOD_STOCK_COUNT_EN
          if (stock_q[sel_item] == '0) begin
            sold_out_d = 1'b1;
          end else
`endif
          if ({1'b0, credit_q} >= price) begin
            credit_d    = 8'(credit_pre - price);
            disp_req_d  = 1'b1;
            disp_item_d = sel_item;
            entry_d     = 1'b1;
            state_d     = DISPENSE;
          end else begin
            err_funds_d = 1'b1;
          end
        end
      end
      DISPENSE: begin
        coin_reject_d = coin_valid;
        if (!entry_q && disp_done) begin
          disp_req_d = 1'b0;
          state_d    = (credit_q != '0) ? CHANGE : IDLE;
`ifdef FOOD_STOCK_COUNT_EN
          stock_d[disp_item_q] = stock_q[disp_item_q] - 4'd1;
`endif
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        credit_d      = (credit_q != '0) ? credit_q - 8'd1 : '0;
        if (credit_q <= 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      disp_req_q    <= 1'b0;
      disp_item_q   <= '0;
      entry_q       <= 1'b0;
      err_funds_q   <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_req_q    <= disp_req_d;
      disp_item_q   <= disp_item_d;
      entry_q       <= entry_d;
      err_funds_q   <= err_funds_d;
      coin_reject_q <= coin_reject_d;
    end
  end

`ifdef FOOD_STOCK_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sold_out_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) stock_q[i] <= 4'(STOCK_INIT);
    end else begin
      sold_out_q <= sold_out_d;
      stock_q    <= stock_d;
    end
  end

  assign sold_out = sold_out_q;
`endif

  assign credit       = credit_q;
  assign disp_req     = disp_req_q;
  assign disp_item    = disp_item_q;
  assign change_pulse = (state_q == CHANGE);
  assign busy         = (state_q == DISPENSE) || (state_q == CHANGE);
  assign err_funds    = err_funds_q;
  assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_food_vend_ctrl.sv
// Scoreboard bench for food_vend_ctrl: a rule-level vending model pushes expected per-cycle outputs, a monitor pops and compares.
module tb_food_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_valid = 1'b0;
  logic [3:0] coin_val = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = '0;
  logic       cancel = 1'b0;
  logic       disp_done = 1'b0;
  logic [7:0] credit;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       change_pulse;
  logic       busy;
  logic       err_funds;
  logic       coin_reject;
  logic       sold_out;

  always #5 clk = ~clk;

  food_vend_ctrl #(.PRICE0(5), .PRICE1(7), .PRICE2(10), .PRICE3(12), .STOCK_INIT(3)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel), .disp_done(disp_done),
    .credit(credit), .disp_req(disp_req), .disp_item(disp_item), .change_pulse(change_pulse),
    .busy(busy), .err_funds(err_funds),
`ifdef FOOD_STOCK_COUNT_EN
    .coin_reject(coin_reject), .sold_out(sold_out)
`else
    .coin_reject(coin_reject)
`endif
  );

`ifndef FOOD_STOCK_COUNT_EN
  assign sold_out = 1'b0;
`endif

  typedef struct {
    int credit;
    bit disp_req;
    int item;
    bit busy;
    bit chg;
    bit err;
    bit rej;
    bit sold;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: credit as a plain integer, vending/refunding as activities.
  int m_credit;
  bit m_vend, m_fresh, m_refund, m_err, m_rej, m_sold;
  int m_item;
  int m_stock[4];

  function automatic int prc(input int i);
    case (i)
      0: return 5;
      1: return 7;
      2: return 10;
      default: return 12;
    endcase
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function void model_reset();
    m_credit = 0; m_vend = 0; m_fresh = 0; m_refund = 0;
    m_err = 0; m_rej = 0; m_sold = 0; m_item = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 3;
  endfunction

  function void model_step(input bit cv, input int cval, input bit sv, input int si,
                           input bit cn, input bit dd);
    int pre;
    bit take;
    m_err = 0; m_rej = 0; m_sold = 0;
    if (m_vend) begin
      if (cv) m_rej = 1;
      if (!m_fresh && dd) begin
        m_vend = 0;
        m_refund = (m_credit > 0);
        m_stock[m_item] = m_stock[m_item] - 1;
      end
      m_fresh = 0;
    end else if (m_refund) begin
      if (cv) m_rej = 1;
      m_credit = m_credit - 1;
      if (m_credit == 0) m_refund = 0;
    end else begin
      pre = m_credit;
      take = cv && (cval > 0) && (pre + cval <= 255);
      if (cv && !take) m_rej = 1;
      m_credit = pre + (take ? cval : 0);
      if (cn) begin
        if (pre > 0) m_refund = 1;
      end else if (sv) begin
`ifdef FOOD_STOCK_COUNT_EN
        if (m_stock[si] == 0) m_sold = 1;
        else
`endif
        if (pre >= prc(si)) begin
          m_credit = m_credit - prc(si);
          m_vend = 1; m_fresh = 1; m_item = si;
        end else begin
          m_err = 1;
        end
      end
    end
  endfunction

  function void push_expected();
    exp_t e;
    e.credit = m_credit; e.disp_req = m_vend; e.item = m_item;
    e.busy = m_vend || m_refund; e.chg = m_refund;
    e.err = m_err; e.rej = m_rej; e.sold = m_sold;
    sb_q.push_back(e);
  endfunction

  task automatic cycle(input bit cv, input int cval, input bit sv, input int si,
                       input bit cn, input bit dd);
    coin_valid = cv; coin_val = 4'(cval); sel_valid = sv; sel_item = 2'(si);
    cancel = cn; disp_done = dd;
    @(posedge clk); #1;
    model_step(cv, cval, sv, si, cn, dd);
    push_expected();
  endtask

  task automatic idle(input int n, input bit dd);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, dd);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    coin_valid = 0; sel_valid = 0; cancel = 0; disp_done = 0;
    #1;
    check("rst_credit", int'(credit), 0);
    check("rst_disp_req", int'(disp_req), 0);
    check("rst_disp_item", int'(disp_item), 0);
    check("rst_change_pulse", int'(change_pulse), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err_funds", int'(err_funds), 0);
    check("rst_coin_reject", int'(coin_reject), 0);
    check("rst_sold_out", int'(sold_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    push_expected();
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("credit", int'(credit), e.credit);
        check("disp_req", int'(disp_req), int'(e.disp_req));
        if (e.disp_req) check("disp_item", int'(disp_item), e.item);
        check("busy", int'(busy), int'(e.busy));
        check("change_pulse", int'(change_pulse), int'(e.chg));
        check("err_funds", int'(err_funds), int'(e.err));
        check("coin_reject", int'(coin_reject), int'(e.rej));
        check("sold_out", int'(sold_out), int'(e.sold));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Coins 5,5, buy item1 (7), hold dispense, then 3 change units.
    cycle(1, 5, 0, 0, 0, 0);
    cycle(1, 5, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    idle(3, 0);
    idle(1, 1);
    idle(5, 0);

    // Insufficient funds then cancel refund.
    cycle(1, 5, 0, 0, 0, 0);
    cycle(0, 0, 1, 3, 0, 0);
    idle(2, 0);
    cycle(0, 0, 0, 0, 1, 0);
    idle(7, 0);

    // Overflow rejection at 250, coin rejected while dispensing.
    for (int i = 0; i < 16; i++) cycle(1, 15, 0, 0, 0, 0);
    cycle(1, 10, 0, 0, 0, 0);
    cycle(1, 10, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 3, 0, 0, 0, 1);
    cycle(1, 3, 0, 0, 0, 0);
    idle(1, 1);
    idle(250, 0);

    // Coin and select together; then with cancel too.
    cycle(1, 7, 0, 0, 0, 0);
    cycle(1, 3, 1, 1, 0, 1);
    idle(1, 1);
    idle(5, 0);
    cycle(1, 7, 0, 0, 0, 0);
    cycle(1, 3, 1, 1, 1, 0);
    idle(12, 0);

    // Reset during change at credit 4.
    cycle(1, 4, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    do_reset();
    idle(5, 0);

`ifdef FOOD_STOCK_COUNT_EN
    for (int k = 0; k < 3; k++) begin
      cycle(1, 5, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      idle(1, 1);
      idle(2, 0);
    end
    cycle(1, 5, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    idle(3, 0);
    cycle(0, 0, 0, 0, 1, 0);
    idle(7, 0);
    do_reset();
`endif

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(99) < 35, int'($urandom_range(15)),
            $urandom_range(99) < 15, int'($urandom_range(3)),
            $urandom_range(99) < 4, $urandom_range(99) < 30);
      if ($urandom_range(999) == 0) do_reset();
    end
    idle(3, 0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
